matrix_loader: RTL and testbench
================================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 The block SHALL expose exactly the following parameter and ports, in this order (clock and reset first).
REQ-002 ELEM_W, default 8: signed element width in bits.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse beginning a new matrix load.
REQ-006 size  input  3  matrix order n, valid values 2..5; present only with MATRIX_LOADER_SIZE_EN.
REQ-007 in_valid  input  1  in_data holds an element.
REQ-008 in_data  input  ELEM_W  signed element, row-major order.
REQ-009 in_ready  output  1  loader accepts an element this cycle.
REQ-010 matrix  output  25*ELEM_W  assembled 5x5 matrix, fed to det5.
REQ-011 mat_valid  output  1  matrix complete and stable.
REQ-012 det_in  input  ELEM_W  det5 result.
REQ-013 ovf_in  input  1  det5 overflow flag.
REQ-014 det  output  ELEM_W  registered determinant.
REQ-015 ovf  output  1  registered overflow flag.
REQ-016 done  output  1  det and ovf are valid.

Function
REQ-017 The FSM SHALL have four states: IDLE, LOAD, SETTLE and DONE.
REQ-018 In IDLE or DONE, start SHALL clear matrix to zero, reset the element counter to 0 and go to LOAD; done SHALL then drop the next cycle.
REQ-019 start in LOAD or SETTLE SHALL be ignored.
REQ-020 in_ready SHALL be 1 only in LOAD.
REQ-021 An element SHALL be accepted on any cycle in which in_valid and in_ready are both 1.
REQ-022 in_valid gaps SHALL stall loading with no loss or duplication of elements.
REQ-023 Element k (row r, column c) SHALL be written to slot p = 5*r+c at bits [25*ELEM_W-1-ELEM_W*p -: ELEM_W]; element (0,0) therefore occupies the MSBs.
REQ-024 Acceptance of the last element (k = n*n-1) SHALL move the FSM to SETTLE on the same edge.
REQ-025 mat_valid SHALL be 1 in SETTLE and DONE, and 0 otherwise.
REQ-026 SETTLE SHALL last exactly one cycle; on its exit edge det <= det_in, ovf <= ovf_in, and the FSM moves to DONE.
REQ-027 done SHALL be 1 in DONE only; det, ovf and matrix SHALL hold until the next start.
REQ-028 Latency from acceptance of the last element to done=1 SHALL be 2 clock edges.
REQ-029 The element counter SHALL be 5 bits and SHALL never exceed n*n-1; there is no wrap within a load.
REQ-030 The 5-bit counter SHALL be split into row and column counters: column wraps at n-1 and increments row.

Reset
REQ-031 rst SHALL asynchronously force: state to IDLE; matrix, det and counters to 0; ovf, done, mat_valid and in_ready to 0.
REQ-032 rst asserted mid-load SHALL discard all partially loaded elements; after release, no element SHALL be accepted until start.

Configuration
REQ-033 MATRIX_LOADER_SIZE_EN defined: size SHALL be sampled on start, with values outside 2..5 clamped to 5.
REQ-034 MATRIX_LOADER_SIZE_EN defined: only n*n elements SHALL be loaded into the top-left n x n block; remaining diagonal slots SHALL be set to 1 and off-diagonal slots to 0, so the det5 result equals the n x n determinant.
REQ-035 MATRIX_LOADER_SIZE_EN undefined: the size port SHALL be absent, n SHALL be fixed at 5, and 25 elements SHALL always be loaded.

Structure
REQ-036 A shared package matrix_pkg SHALL hold: ELEM_W=8, N_MAX=5, MAT_W=N_MAX*N_MAX*ELEM_W=200, and the loader_state_t enum {IDLE, LOAD, SETTLE, DONE}.
REQ-037 One sub-module, loader_idx_cnt, SHALL provide the row/column counter with n-dependent wrap and a last-element flag.
REQ-038 det5 SHALL be instantiated by the parent, not inside matrix_loader.

Verification
REQ-039 Reset mid-load: start, 12 elements, then rst -> matrix=0, in_ready=0, done=0; the following start with a full load succeeds.
REQ-040 Full load with det5 attached: 2,3,2,5,6,3,2,2,1,4,3,1,3,2,1,1,1,0,6,5,2,1,2,1,3 -> matrix[199:192]=2, matrix[7:0]=3; done 2 cycles after the last element; det=-90 (0xA6); ovf equals det5 ovf_in.
REQ-041 Backpressure: 1,1,1,1,1,1,1,1,0,1,1,2,1,1,1,0,0,1,1,1,1,1,0,1,1 with in_valid toggling every other cycle -> identical matrix to the gap-free load; det=-1 (0xFF); ovf=0.
REQ-042 Ignored start: start pulsed during LOAD -> counter unchanged and load completes normally.
REQ-043 Restart from DONE: start -> done=0 next cycle, matrix=0, in_ready=1.
REQ-044 With MATRIX_LOADER_SIZE_EN: size=2, elements 3,1,2,4 -> matrix slots 0,1,5,6 = 3,1,2,4; slots 12,18,24 = 1; all other slots 0; det=10.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix loader slice.
// Holds the element/matrix geometry, the loader FSM state type and a helper that
// maps a requested matrix order onto the supported range 2..5.
package matrix_pkg;

  localparam int unsigned ELEM_W = 8;
  localparam int unsigned N_MAX  = 5;
  localparam int unsigned MAT_W  = N_MAX * N_MAX * ELEM_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    DONE
  } loader_state_t;

  // Orders outside 2..5 fall back to the full 5x5 matrix.
  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    return ((s < 3'd2) || (s > 3'd5)) ? 3'd5 : s;
  endfunction

endpackage

// File: rtl/loader_idx_cnt.sv
// Row/column element counter for the matrix loader.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear to element (0,0)
//   inc       : advance to the next element (ignored once the last one is reached)
//   n         : matrix order, 2..5
//   row, col  : position of the next element to be written
//   slot      : 5-bit linear slot 5*row+col inside the 5x5 matrix
//   last      : next element is the final one (row = col = n-1)
module loader_idx_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic [2:0] n,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic [4:0] slot,
  output logic       last
);

  logic col_wrap;

  assign col_wrap = (col == n - 3'd1);
  assign last     = col_wrap && (row == n - 3'd1);
  assign slot     = 5'(row) * 5'd5 + 5'(col);

  // Holding on the last element keeps the count inside 0..n*n-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc && !last) begin
      if (col_wrap) begin
        col <= '0;
        row <= row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Matrix loader: streams signed elements in row-major order into a 5x5 matrix for
// an external det5 block, then registers det5's result one cycle after the matrix
// is complete.
// Optional feature macro: MATRIX_LOADER_SIZE_EN adds the size port so smaller
// n x n matrices can be loaded; the unused part is filled with an identity block.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a new load (honoured in IDLE/DONE only)
//   size       : matrix order 2..5 (MATRIX_LOADER_SIZE_EN only)
//   in_valid   : in_data holds an element
//   in_data    : signed element
//   in_ready   : element accepted when in_valid && in_ready
//   matrix     : assembled matrix, element (0,0) in the MSBs
//   mat_valid  : matrix complete and stable
//   det_in     : det5 result
//   ovf_in     : det5 overflow flag
//   det, ovf   : registered det5 result/overflow
//   done       : det and ovf are valid
module matrix_loader #(
  parameter int unsigned ELEM_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
`ifdef MATRIX_LOADER_SIZE_EN
  input  logic [2:0]               size,
`endif
  input  logic                     in_valid,
  input  logic [ELEM_W-1:0]        in_data,
  output logic                     in_ready,
  output logic [25*ELEM_W-1:0]     matrix,
  output logic                     mat_valid,
  input  logic [ELEM_W-1:0]        det_in,
  input  logic                     ovf_in,
  output logic [ELEM_W-1:0]        det,
  output logic                     ovf,
  output logic                     done
);

  import matrix_pkg::*;

  localparam int unsigned MAT_BITS = N_MAX * N_MAX * ELEM_W;

  loader_state_t         state;
  logic [2:0]            ord;
  logic [2:0]            row;
  logic [2:0]            col;
  logic [4:0]            slot;
  logic                  last;
  logic                  begin_load;
  logic                  accept;
  logic [MAT_BITS-1:0]   init_mat;

  assign begin_load = start && ((state == IDLE) || (state == DONE));
  assign accept     = in_valid && in_ready;

`ifdef MATRIX_LOADER_SIZE_EN
  logic [2:0] new_ord;

  assign new_ord = clamp_size(size);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ord <= 3'd5;
    end else if (begin_load) begin
      ord <= new_ord;
    end
  end

  // Diagonal slots beyond the loaded n x n block are 1 so det5 sees the
  // determinant of the small block unchanged.
  always_comb begin
    init_mat = '0;
    for (int i = 0; i < int'(N_MAX); i++) begin
      if (i >= int'(new_ord)) begin
        init_mat[MAT_BITS-1-ELEM_W*(6*i) -: ELEM_W] = ELEM_W'(1);
      end
    end
  end
`else
  assign ord      = 3'd5;
  assign init_mat = '0;
`endif

  loader_idx_cnt u_idx_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (begin_load),
    .inc  (accept),
    .n    (ord),
    .row  (row),
    .col  (col),
    .slot (slot),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      matrix    <= '0;
      det       <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
      mat_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            matrix    <= init_mat;
            state     <= LOAD;
            in_ready  <= 1'b1;
            done      <= 1'b0;
            mat_valid <= 1'b0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            matrix[MAT_BITS-1-ELEM_W*int'(slot) -: ELEM_W] <= in_data;
            if (last) begin
              state     <= SETTLE;
              in_ready  <= 1'b0;
              mat_valid <= 1'b1;
            end
          end
        end
        SETTLE: begin
          // det5 has had a full cycle on the stable matrix.
          det   <= det_in;
          ovf   <= ovf_in;
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // row/col are consumed through slot and last.
  logic unused_rc;
  assign unused_rc = ^{row, col};

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: directed sequence with randomized loads,
// checked against a behavioural matrix/determinant model.
module tb_matrix_loader;

  localparam int EW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
`ifdef MATRIX_LOADER_SIZE_EN
  logic [2:0]      size;
`endif
  logic            in_valid;
  logic [EW-1:0]   in_data;
  logic            in_ready;
  logic [25*EW-1:0] matrix;
  logic            mat_valid;
  logic [EW-1:0]   det_in;
  logic            ovf_in;
  logic [EW-1:0]   det;
  logic            ovf;
  logic            done;

  matrix_loader #(.ELEM_W(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef MATRIX_LOADER_SIZE_EN
    .size      (size),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .matrix    (matrix),
    .mat_valid (mat_valid),
    .det_in    (det_in),
    .ovf_in    (ovf_in),
    .det       (det),
    .ovf       (ovf),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int elems[25];

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected matrix: identity padding outside the n x n block, then elements row-major.
  function automatic logic [199:0] model_mat(input int n, input bit filled);
    logic [199:0] m;
    int slot;
    m = '0;
    for (int i = n; i < 5; i++) m[199-EW*(6*i) -: EW] = 8'd1;
    if (filled) begin
      for (int k = 0; k < n * n; k++) begin
        slot = 5 * (k / n) + (k % n);
        m[199-EW*slot -: EW] = EW'(elems[k]);
      end
    end
    return m;
  endfunction

  // Exact integer determinant (Bareiss) of the n x n block of elems.
  function automatic longint model_det(input int n);
    longint m[5][5];
    longint prev;
    longint tmp;
    int     sgn;
    int     p;
    prev = 1;
    sgn  = 1;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) m[i][j] = longint'(elems[i*n+j]);
    for (int k = 0; k < n - 1; k++) begin
      if (m[k][k] == 0) begin
        p = -1;
        for (int i = k + 1; i < n; i++) if (p < 0 && m[i][k] != 0) p = i;
        if (p < 0) return 0;
        for (int j = 0; j < n; j++) begin
          tmp = m[k][j]; m[k][j] = m[p][j]; m[p][j] = tmp;
        end
        sgn = -sgn;
      end
      for (int i = k + 1; i < n; i++)
        for (int j = k + 1; j < n; j++)
          m[i][j] = (m[i][j] * m[k][k] - m[i][k] * m[k][j]) / prev;
      prev = m[k][k];
    end
    return sgn * m[n-1][n-1];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [2:0] sz);
    start = 1'b1;
`ifdef MATRIX_LOADER_SIZE_EN
    size = sz;
`else
    if (sz == 3'd0) start = 1'b1;
`endif
    step();
    start = 1'b0;
  endtask

  // Stream n*n elements; optional idle gap after each but the last, and an
  // optional start pulse alongside element start_at (and its gap).
  task automatic send_all(input int n, input bit gaps, input int start_at);
    int t;
    for (int k = 0; k < n * n; k++) begin
      in_data  = EW'(elems[k]);
      in_valid = 1'b1;
      start    = (k == start_at);
      t = 0;
      while (!in_ready && t < 50) begin
        step();
        t++;
      end
      check("ready_wait", (t < 50), 1);
      step();
      in_valid = 1'b0;
      if (gaps && k != n * n - 1) begin
        in_data = EW'($urandom);
        step();
      end
      start = 1'b0;
    end
  endtask

  task automatic run_load(input string tag, input int n, input bit gaps, input int start_at,
                          input logic [EW-1:0] dval, input logic oval, input bit settle_start);
    det_in = dval;
    ovf_in = oval;
    send_all(n, gaps, start_at);
    // One edge after the last acceptance: SETTLE.
    check({tag, "_settle_mv"}, mat_valid, 1);
    check({tag, "_settle_done"}, done, 0);
    check({tag, "_settle_rdy"}, in_ready, 0);
    start = settle_start;
    step();
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_det"}, det, dval);
    check({tag, "_ovf"}, ovf, oval);
    check({tag, "_mat"}, matrix, model_mat(n, 1'b1));
    det_in = ~dval;
    ovf_in = ~oval;
    step();
    step();
    check({tag, "_hold_det"}, det, dval);
    check({tag, "_hold_done"}, done, 1);
    check({tag, "_hold_mat"}, matrix, model_mat(n, 1'b1));
  endtask

  task automatic model_load(input string tag, input int n, input bit gaps, input int start_at,
                            input bit settle_start);
    longint d;
    logic   o;
    d = model_det(n);
    o = (d > 127) || (d < -128);
    run_load(tag, n, gaps, start_at, EW'(d), o, settle_start);
  endtask

  int full_vec[25] = '{2,3,2,5,6, 3,2,2,1,4, 3,1,3,2,1, 1,1,0,6,5, 2,1,2,1,3};
  int bp_vec[25]   = '{1,1,1,1,1, 1,1,1,0,1, 1,2,1,1,1, 0,0,1,1,1, 1,1,0,1,1};

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; det_in = '0; ovf_in = 1'b0;
`ifdef MATRIX_LOADER_SIZE_EN
    size = 3'd5;
`endif
    step();
    step();
    check("rst_matrix", matrix, 0);
    check("rst_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_mv", mat_valid, 0);
    check("rst_det", det, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;

    // No acceptance without start.
    in_valid = 1'b1; in_data = 8'h5a;
    step(); step();
    check("idle_ready", in_ready, 0);
    check("idle_matrix", matrix, 0);
    in_valid = 1'b0;

    // Reset mid-load discards the partial matrix asynchronously.
    for (int k = 0; k < 25; k++) elems[k] = $urandom_range(1, 255);
    pulse_start(3'd5);
    check("start_ready", in_ready, 1);
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1; in_data = EW'(elems[k]);
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_matrix", matrix, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_done", done, 0);
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h33;
    step(); step();
    in_valid = 1'b0;
    check("post_rst_matrix", matrix, 0);
    check("post_rst_ready", in_ready, 0);

    // Full gap-free load.
    for (int k = 0; k < 25; k++) elems[k] = full_vec[k];
    pulse_start(3'd5);
    model_load("full", 5, 1'b0, -1, 1'b0);
    check("full_msb", matrix[199:192], 8'd2);
    check("full_lsb", matrix[7:0], 8'd3);

    // Restart from DONE.
    pulse_start(3'd5);
    check("restart_done", done, 0);
    check("restart_matrix", matrix, model_mat(5, 1'b0));
    check("restart_ready", in_ready, 1);
    check("restart_mv", mat_valid, 0);

    // Backpressure with in_valid toggling; start pulsed in SETTLE is ignored.
    for (int k = 0; k < 25; k++) elems[k] = bp_vec[k];
    model_load("bp", 5, 1'b1, -1, 1'b1);

    // Start pulsed during LOAD is ignored.
    for (int k = 0; k < 25; k++) elems[k] = int'($urandom_range(0, 255)) - 128;
    pulse_start(3'd5);
    model_load("ign_start", 5, 1'b0, 7, 1'b0);

    // Randomized loads with random gaps and arbitrary det5 responses.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 25; k++) elems[k] = int'($urandom_range(0, 255)) - 128;
      pulse_start(3'd5);
      run_load("rand", 5, r[0], 30, EW'($urandom), 1'($urandom), 1'b0);
    end

`ifdef MATRIX_LOADER_SIZE_EN
    elems[0] = 3; elems[1] = 1; elems[2] = 2; elems[3] = 4;
    pulse_start(3'd2);
    check("sz2_init", matrix, model_mat(2, 1'b0));
    model_load("sz2", 2, 1'b0, -1, 1'b0);
    check("sz2_det10", det, 8'd10);
    for (int k = 0; k < 25; k++) elems[k] = int'($urandom_range(0, 255)) - 128;
    pulse_start(3'd7);
    model_load("sz_clamp", 5, 1'b1, -1, 1'b0);
    for (int k = 0; k < 9; k++) elems[k] = int'($urandom_range(0, 9)) - 4;
    pulse_start(3'd3);
    model_load("sz3", 3, 1'b1, -1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
